tm_sequencer: RTL

TM_SEQUENCER -- requirements
Module: tm_sequencer

---
 rtl/tm_pkg.sv | 15 +
 rtl/tm_sequencer_if.sv | 23 ++
 rtl/btn_edge.sv | 20 ++
 rtl/tm_sequencer.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/tm_pkg.sv
// Shared types and default sizing for the tape-machine sequencer.
package tm_pkg;

    localparam int DATA_W   = 4;
    localparam int TAPE_LEN = 64;

    typedef enum logic [2:0] {
        S_LOAD,
        S_START,
        S_RUN,
        S_SHOW,
        S_TIMEOUT
    } seq_state_t;

endpackage

// File: rtl/tm_sequencer_if.sv
// Tape memory and machine control bus between the sequencer (master) and the tape/machine (slave).
interface tm_sequencer_if #(
    parameter int DATA_W = tm_pkg::DATA_W,
    parameter int AW     = $clog2(tm_pkg::TAPE_LEN)
);
    logic              tape_we;
    logic [AW-1:0]     tape_addr;
    logic [DATA_W-1:0] tape_wdata;
    logic [DATA_W-1:0] tape_rdata;
    logic              tm_start;
    logic              tm_step;
    logic              tm_halt;

    modport master (
        output tape_we, tape_addr, tape_wdata, tm_start, tm_step,
        input  tape_rdata, tm_halt
    );

    modport slave (
        input  tape_we, tape_addr, tape_wdata, tm_start, tm_step,
        output tape_rdata, tm_halt
    );
endinterface

// File: rtl/btn_edge.sv
// Rising-edge detector for a level button already synchronous to clock.
module btn_edge (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic rise
);
    logic prev_q;
    logic prev_d;

    always_comb prev_d = level;

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) prev_q <= 1'b0;
        else       prev_q <= prev_d;
    end

    assign rise = level & ~prev_q;
endmodule

// File: rtl/tm_sequencer.sv
// Sequencer for a tape machine: loads the tape from switches, runs the machine
// with a step budget, then lets the user browse the resulting tape.
module tm_sequencer #(
    parameter  int DATA_W    = tm_pkg::DATA_W,
    parameter  int TAPE_LEN  = tm_pkg::TAPE_LEN,
    parameter  int MAX_STEPS = 4096,
    localparam int AW        = $clog2(TAPE_LEN)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] input_data,
    input  logic              Next,
    input  logic              Done,
    output logic              tape_we,
    output logic [AW-1:0]     tape_addr,
    output logic [DATA_W-1:0] tape_wdata,
    input  logic [DATA_W-1:0] tape_rdata,
    output logic              tm_start,
    output logic              tm_step,
    input  logic              tm_halt,
    output logic [10:0]       display,
    output logic              Compute_done
);
    import tm_pkg::*;

    localparam int SW = $clog2(MAX_STEPS + 1);

    logic next_ev, done_ev;

    btn_edge u_next_edge (.clock(clock), .reset(reset), .level(Next), .rise(next_ev));
    btn_edge u_done_edge (.clock(clock), .reset(reset), .level(Done), .rise(done_ev));

    seq_state_t        state_q, state_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic              full_q, full_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic [SW-1:0]     step_cnt_q, step_cnt_d;
    logic              tape_we_q, tape_we_d;
    logic [AW-1:0]     tape_addr_q, tape_addr_d;
    logic [DATA_W-1:0] tape_wdata_q, tape_wdata_d;
    logic              tm_start_q, tm_start_d;
    logic              tm_step_q, tm_step_d;
    logic              compute_done_q, compute_done_d;

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        full_d       = full_q;
        rd_addr_d    = rd_addr_q;
        step_cnt_d   = step_cnt_q;
        tape_we_d    = 1'b0;
        tape_addr_d  = tape_addr_q;
        tape_wdata_d = tape_wdata_q;

        unique case (state_q)
            S_LOAD: begin
                if (done_ev) begin
                    state_d = S_START;
                end else if (next_ev && !full_q) begin
                    tape_we_d    = 1'b1;
                    tape_addr_d  = wr_addr_q;
                    tape_wdata_d = input_data;
                    // Last cell sets full and holds wr_addr instead of wrapping.
                    if (wr_addr_q == AW'(TAPE_LEN - 1)) full_d    = 1'b1;
                    else                                wr_addr_d = wr_addr_q + 1'b1;
                end
            end
            S_START: begin
                step_cnt_d = '0;
                state_d    = S_RUN;
            end
            S_RUN: begin
                step_cnt_d = step_cnt_q + 1'b1;
                if (tm_halt)                                state_d = S_SHOW;
                else if (step_cnt_q == SW'(MAX_STEPS - 1))  state_d = S_TIMEOUT;
                if (state_d != S_RUN)                       rd_addr_d = '0;
            end
            S_SHOW, S_TIMEOUT: begin
                if (done_ev) begin
                    state_d   = S_LOAD;
                    wr_addr_d = '0;
                    full_d    = 1'b0;
                end else if (next_ev) begin
                    rd_addr_d = (rd_addr_q == AW'(TAPE_LEN - 1)) ? '0 : rd_addr_q + 1'b1;
                end
            end
            default: state_d = S_LOAD;
        endcase

        // While browsing, the tape address tracks the read pointer.
        if (state_d == S_SHOW || state_d == S_TIMEOUT) tape_addr_d = rd_addr_d;

        tm_start_d     = (state_d == S_START);
        tm_step_d      = (state_d == S_RUN);
        compute_done_d = (state_d == S_SHOW) || (state_d == S_TIMEOUT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_LOAD;
            wr_addr_q      <= '0;
            full_q         <= 1'b0;
            rd_addr_q      <= '0;
            step_cnt_q     <= '0;
            tape_we_q      <= 1'b0;
            tape_addr_q    <= '0;
            tape_wdata_q   <= '0;
            tm_start_q     <= 1'b0;
            tm_step_q      <= 1'b0;
            compute_done_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_addr_q      <= wr_addr_d;
            full_q         <= full_d;
            rd_addr_q      <= rd_addr_d;
            step_cnt_q     <= step_cnt_d;
            tape_we_q      <= tape_we_d;
            tape_addr_q    <= tape_addr_d;
            tape_wdata_q   <= tape_wdata_d;
            tm_start_q     <= tm_start_d;
            tm_step_q      <= tm_step_d;
            compute_done_q <= compute_done_d;
        end
    end

    always_comb begin
        display = '0;
        unique case (state_q)
            S_LOAD:    display = {6'(wr_addr_q), 4'(input_data), full_q};
            S_SHOW:    display = {6'(rd_addr_q), 4'(tape_rdata), 1'b0};
            S_TIMEOUT: display = {6'(rd_addr_q), 4'(tape_rdata), 1'b1};
            default:   display = '0;
        endcase
    end

    assign tape_we      = tape_we_q;
    assign tape_addr    = tape_addr_q;
    assign tape_wdata   = tape_wdata_q;
    assign tm_start     = tm_start_q;
    assign tm_step      = tm_step_q;
    assign Compute_done = compute_done_q;
endmodule
